store_load_buffer: RTL and testbench

STORE_LOAD_BUFFER -- requirements
Module: store_load_buffer

---
 rtl/store_load_buffer_pkg.sv | 23 ++
 rtl/store_load_buffer_if.sv | 15 +
 rtl/slb_load_align.sv | 23 ++
 rtl/store_load_buffer.sv | 194 +++++++++++++++++++
 tb/tb_store_load_buffer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_load_buffer_pkg.sv
// rtl/store_load_buffer_pkg.sv - shared sizes, op codes and encodings for the store/load buffer
package store_load_buffer_pkg;
   localparam int SLB_LOG      = 4;
   localparam int SLB_SIZE     = 1 << SLB_LOG;
   localparam int ROB_SIZE_LOG = 4;
   localparam int OP_SIZE_LOG  = 6;

   localparam logic [OP_SIZE_LOG-1:0] OP_LB  = 6'd1;
   localparam logic [OP_SIZE_LOG-1:0] OP_LH  = 6'd2;
   localparam logic [OP_SIZE_LOG-1:0] OP_LW  = 6'd3;
   localparam logic [OP_SIZE_LOG-1:0] OP_LBU = 6'd4;
   localparam logic [OP_SIZE_LOG-1:0] OP_LHU = 6'd5;
   localparam logic [OP_SIZE_LOG-1:0] OP_SB  = 6'd6;
   localparam logic [OP_SIZE_LOG-1:0] OP_SH  = 6'd7;
   localparam logic [OP_SIZE_LOG-1:0] OP_SW  = 6'd8;

   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_e;
   typedef enum logic [1:0] {IDLE, MEM_LOAD, STORE_WAIT, MEM_STORE} slb_state_e;

   function automatic logic is_store(input logic [OP_SIZE_LOG-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction
endpackage

// File: rtl/store_load_buffer_if.sv
// rtl/store_load_buffer_if.sv - memory request/completion bus between the buffer and memory
interface store_load_buffer_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_done;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
                   input  mem_done, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
                   output mem_done, mem_rdata);
endinterface

// File: rtl/slb_load_align.sv
// rtl/slb_load_align.sv - access size decode and load sign/zero extension
module slb_load_align
   import store_load_buffer_pkg::*;
(
   input  logic [OP_SIZE_LOG-1:0] op,
   input  logic [31:0]            rdata,
   output logic [31:0]            value,
   output logic [1:0]             size
);
   always_comb begin
      value = rdata;
      size  = SZ_WORD;
      case (op)
         OP_LB:  begin value = {{24{rdata[7]}}, rdata[7:0]};   size = SZ_BYTE; end
         OP_LH:  begin value = {{16{rdata[15]}}, rdata[15:0]}; size = SZ_HALF; end
         OP_LBU: begin value = {24'b0, rdata[7:0]};            size = SZ_BYTE; end
         OP_LHU: begin value = {16'b0, rdata[15:0]};           size = SZ_HALF; end
         OP_SB:  size = SZ_BYTE;
         OP_SH:  size = SZ_HALF;
         default: size = SZ_WORD;
      endcase
   end
endmodule

// File: rtl/store_load_buffer.sv
// rtl/store_load_buffer.sv - in-order store/load ring; only the head entry talks to memory
module store_load_buffer
   import store_load_buffer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    iss_valid,
   input  logic [OP_SIZE_LOG-1:0]  iss_op,
   input  logic [ROB_SIZE_LOG-1:0] iss_robid,
   input  logic [31:0]             iss_imm,
   input  logic [31:0]             iss_v1,
   input  logic [31:0]             iss_v2,
   input  logic [ROB_SIZE_LOG:0]   iss_q1,
   input  logic [ROB_SIZE_LOG:0]   iss_q2,
   input  logic                    cdb_valid,
   input  logic [ROB_SIZE_LOG-1:0] cdb_robid,
   input  logic [31:0]             cdb_value,
   input  logic                    commit_store_valid,
   input  logic [ROB_SIZE_LOG-1:0] commit_store_robid,
   store_load_buffer_if.master     mem,
   output logic                    res_load_valid,
   output logic                    res_store_valid,
   output logic [ROB_SIZE_LOG-1:0] res_robid,
   output logic [31:0]             res_value,
   output logic                    full
);
   localparam logic [SLB_LOG:0] CNT_MAX = SLB_SIZE[SLB_LOG:0];

   logic                    e_valid [SLB_SIZE];
   logic                    e_p1    [SLB_SIZE];
   logic                    e_p2    [SLB_SIZE];
   logic [OP_SIZE_LOG-1:0]  e_op    [SLB_SIZE];
   logic [ROB_SIZE_LOG-1:0] e_robid [SLB_SIZE];
   logic [ROB_SIZE_LOG-1:0] e_q1    [SLB_SIZE];
   logic [ROB_SIZE_LOG-1:0] e_q2    [SLB_SIZE];
   logic [31:0]             e_imm   [SLB_SIZE];
   logic [31:0]             e_v1    [SLB_SIZE];
   logic [31:0]             e_v2    [SLB_SIZE];

   logic [SLB_LOG-1:0] head, tail;
   logic [SLB_LOG:0]   count;
   slb_state_e         state, state_d;
   logic               pop, accept, start_load, start_store, report_store;
   logic               iss_hit1, iss_hit2;
   logic [31:0]        ld_value, head_addr;
   logic [1:0]         head_size;

   slb_load_align u_align (
      .op    (e_op[head]),
      .rdata (mem.mem_rdata),
      .value (ld_value),
      .size  (head_size)
   );

   assign full      = (count >= CNT_MAX - 1'b1);
   assign head_addr = e_v1[head] + e_imm[head];
   assign iss_hit1  = cdb_valid && iss_q1[ROB_SIZE_LOG] && (iss_q1[ROB_SIZE_LOG-1:0] == cdb_robid);
   assign iss_hit2  = cdb_valid && iss_q2[ROB_SIZE_LOG] && (iss_q2[ROB_SIZE_LOG-1:0] == cdb_robid);

   always_comb begin
      state_d      = state;
      pop          = 1'b0;
      start_load   = 1'b0;
      start_store  = 1'b0;
      report_store = 1'b0;
      case (state)
         IDLE: if (count != '0 && !e_p1[head]) begin
            if (!is_store(e_op[head])) begin
               start_load = 1'b1;
               state_d    = MEM_LOAD;
            end else if (!e_p2[head]) begin
               report_store = 1'b1;
               state_d      = STORE_WAIT;
            end
         end
         MEM_LOAD:   if (mem.mem_done) begin pop = 1'b1; state_d = IDLE; end
         STORE_WAIT: if (commit_store_valid && commit_store_robid == e_robid[head]) begin
            start_store = 1'b1;
            state_d     = MEM_STORE;
         end
         MEM_STORE:  if (mem.mem_done) begin pop = 1'b1; state_d = IDLE; end
         default:    state_d = IDLE;
      endcase
      // A committed store in flight survives a flush; everything else is dropped.
      if (flush && state != MEM_STORE) begin
         state_d      = IDLE;
         pop          = 1'b0;
         start_load   = 1'b0;
         start_store  = 1'b0;
         report_store = 1'b0;
      end
      accept = iss_valid && !flush && (count != CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         mem.mem_req     <= 1'b0;
         mem.mem_we      <= 1'b0;
         mem.mem_addr    <= '0;
         mem.mem_wdata   <= '0;
         mem.mem_size    <= '0;
         res_load_valid  <= 1'b0;
         res_store_valid <= 1'b0;
         res_robid       <= '0;
         res_value       <= '0;
         for (int i = 0; i < SLB_SIZE; i++) begin
            e_valid[i] <= 1'b0;
            e_p1[i]    <= 1'b0;
            e_p2[i]    <= 1'b0;
            e_op[i]    <= '0;
            e_robid[i] <= '0;
            e_q1[i]    <= '0;
            e_q2[i]    <= '0;
            e_imm[i]   <= '0;
            e_v1[i]    <= '0;
            e_v2[i]    <= '0;
         end
      end else if (rdy) begin
         state           <= state_d;
         res_load_valid  <= 1'b0;
         res_store_valid <= 1'b0;
         for (int i = 0; i < SLB_SIZE; i++) begin
            if (cdb_valid && e_valid[i] && e_p1[i] && e_q1[i] == cdb_robid) begin
               e_v1[i] <= cdb_value;
               e_p1[i] <= 1'b0;
            end
            if (cdb_valid && e_valid[i] && e_p2[i] && e_q2[i] == cdb_robid) begin
               e_v2[i] <= cdb_value;
               e_p2[i] <= 1'b0;
            end
         end
         if (start_load || start_store) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= start_store;
            mem.mem_addr  <= head_addr;
            mem.mem_size  <= head_size;
         end
         if (start_store)
            mem.mem_wdata <= e_v2[head];
         if (report_store) begin
            res_store_valid <= 1'b1;
            res_robid       <= e_robid[head];
         end
         if (pop) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            e_valid[head] <= 1'b0;
            head          <= head + 1'b1;
            if (state == MEM_LOAD) begin
               res_load_valid <= 1'b1;
               res_robid      <= e_robid[head];
               res_value      <= ld_value;
            end
         end
         if (accept) begin
            e_valid[tail] <= 1'b1;
            e_op[tail]    <= iss_op;
            e_robid[tail] <= iss_robid;
            e_imm[tail]   <= iss_imm;
            e_q1[tail]    <= iss_q1[ROB_SIZE_LOG-1:0];
            e_q2[tail]    <= iss_q2[ROB_SIZE_LOG-1:0];
            e_p1[tail]    <= iss_q1[ROB_SIZE_LOG] && !iss_hit1;
            e_p2[tail]    <= iss_q2[ROB_SIZE_LOG] && !iss_hit2;
            e_v1[tail]    <= iss_hit1 ? cdb_value : iss_v1;
            e_v2[tail]    <= iss_hit2 ? cdb_value : iss_v2;
            tail          <= tail + 1'b1;
         end
         if (accept && !pop)
            count <= count + 1'b1;
         else if (pop && !accept)
            count <= count - 1'b1;
         if (flush) begin
            for (int i = 0; i < SLB_SIZE; i++)
               if (state != MEM_STORE || SLB_LOG'(i) != head)
                  e_valid[i] <= 1'b0;
            if (state == MEM_STORE) begin
               tail  <= head + 1'b1;
               count <= {{SLB_LOG{1'b0}}, !pop};
            end else begin
               tail        <= head;
               count       <= '0;
               mem.mem_req <= 1'b0;
               mem.mem_we  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_store_load_buffer.sv
// tb/tb_store_load_buffer.sv - directed self-checking bench for store_load_buffer
module tb_store_load_buffer;
   import store_load_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        iss_valid;
   logic [5:0]  iss_op;
   logic [3:0]  iss_robid;
   logic [31:0] iss_imm, iss_v1, iss_v2;
   logic [4:0]  iss_q1, iss_q2;
   logic        cdb_valid;
   logic [3:0]  cdb_robid;
   logic [31:0] cdb_value;
   logic        commit_store_valid;
   logic [3:0]  commit_store_robid;
   logic        res_load_valid, res_store_valid;
   logic [3:0]  res_robid;
   logic [31:0] res_value;
   logic        full;
   int          checks = 0;
   int          errors = 0;

   store_load_buffer_if mem_bus ();

   store_load_buffer dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .flush              (flush),
      .iss_valid          (iss_valid),
      .iss_op             (iss_op),
      .iss_robid          (iss_robid),
      .iss_imm            (iss_imm),
      .iss_v1             (iss_v1),
      .iss_v2             (iss_v2),
      .iss_q1             (iss_q1),
      .iss_q2             (iss_q2),
      .cdb_valid          (cdb_valid),
      .cdb_robid          (cdb_robid),
      .cdb_value          (cdb_value),
      .commit_store_valid (commit_store_valid),
      .commit_store_robid (commit_store_robid),
      .mem                (mem_bus),
      .res_load_valid     (res_load_valid),
      .res_store_valid    (res_store_valid),
      .res_robid          (res_robid),
      .res_value          (res_value),
      .full               (full)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [3:0] robid, input logic [31:0] v1,
                        input logic [31:0] imm, input logic [4:0] q1, input logic [31:0] v2,
                        input logic [4:0] q2);
      iss_valid = 1'b1; iss_op = op; iss_robid = robid; iss_v1 = v1; iss_imm = imm;
      iss_q1 = q1; iss_v2 = v2; iss_q2 = q2;
      tick();
      iss_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (mem_bus.mem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk(tag, 32'(mem_bus.mem_req), 32'd1);
   endtask

   task automatic do_load(input string tag, input logic [5:0] op, input logic [3:0] robid,
                          input logic [31:0] v1, input logic [31:0] imm, input logic [31:0] rdata,
                          input logic [31:0] exp_value, input logic [1:0] exp_size);
      issue(op, robid, v1, imm, 5'd0, 32'd0, 5'd0);
      wait_req({tag, "_req"});
      chk({tag, "_we"}, 32'(mem_bus.mem_we), 32'd0);
      chk({tag, "_addr"}, mem_bus.mem_addr, v1 + imm);
      chk({tag, "_size"}, 32'(mem_bus.mem_size), 32'(exp_size));
      mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = rdata;
      tick();
      mem_bus.mem_done = 1'b0;
      chk({tag, "_rvalid"}, 32'(res_load_valid), 32'd1);
      chk({tag, "_robid"}, 32'(res_robid), 32'(robid));
      chk({tag, "_value"}, res_value, exp_value);
      chk({tag, "_req_drop"}, 32'(mem_bus.mem_req), 32'd0);
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0;
      iss_valid = 1'b0; iss_op = '0; iss_robid = '0; iss_imm = '0; iss_v1 = '0; iss_v2 = '0;
      iss_q1 = '0; iss_q2 = '0; cdb_valid = 1'b0; cdb_robid = '0; cdb_value = '0;
      commit_store_valid = 1'b0; commit_store_robid = '0;
      mem_bus.mem_done = 1'b0; mem_bus.mem_rdata = '0;
      tick(); tick();
      chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
      chk("rst_addr", mem_bus.mem_addr, 32'd0);
      chk("rst_rvalid", 32'(res_load_valid), 32'd0);
      chk("rst_svalid", 32'(res_store_valid), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      rst = 1'b1;
      tick();

      do_load("lw",  OP_LW,  4'd3, 32'h100, 32'h4, 32'hDEADBEEF, 32'hDEADBEEF, 2'd2);
      tick();
      chk("lw_strobe_once", 32'(res_load_valid), 32'd0);
      do_load("lb",  OP_LB,  4'd1, 32'h20, 32'h1, 32'h00000080, 32'hFFFFFF80, 2'd0);
      do_load("lbu", OP_LBU, 4'd2, 32'h20, 32'h2, 32'h00000080, 32'h00000080, 2'd0);
      do_load("lh",  OP_LH,  4'd4, 32'hFFFFFFFE, 32'h4, 32'h00008000, 32'hFFFF8000, 2'd1);
      do_load("lhu", OP_LHU, 4'd5, 32'h40, 32'h6, 32'h00008000, 32'h00008000, 2'd1);

      // operand broadcast arriving on the issue cycle
      cdb_valid = 1'b1; cdb_robid = 4'd6; cdb_value = 32'h300;
      issue(OP_LW, 4'd8, 32'h0, 32'h8, {1'b1, 4'd6}, 32'd0, 5'd0);
      cdb_valid = 1'b0;
      wait_req("iss_cdb_req");
      chk("iss_cdb_addr", mem_bus.mem_addr, 32'h308);
      mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 32'h11;
      tick();
      mem_bus.mem_done = 1'b0;
      chk("iss_cdb_robid", 32'(res_robid), 32'd8);

      // store waiting on data, then on commit
      issue(OP_SW, 4'd5, 32'h200, 32'h0, 5'd0, 32'd0, {1'b1, 4'd2});
      tick();
      chk("sw_no_early_res", 32'(res_store_valid), 32'd0);
      cdb_valid = 1'b1; cdb_robid = 4'd2; cdb_value = 32'd7;
      tick();
      cdb_valid = 1'b0;
      tick();
      chk("sw_res_valid", 32'(res_store_valid), 32'd1);
      chk("sw_res_robid", 32'(res_robid), 32'd5);
      commit_store_valid = 1'b1; commit_store_robid = 4'd4;
      tick(); tick();
      chk("sw_res_once", 32'(res_store_valid), 32'd0);
      chk("sw_no_req_wrong_commit", 32'(mem_bus.mem_req), 32'd0);
      commit_store_robid = 4'd5;
      tick();
      commit_store_valid = 1'b0;
      chk("sw_req", 32'(mem_bus.mem_req), 32'd1);
      chk("sw_we", 32'(mem_bus.mem_we), 32'd1);
      chk("sw_wdata", mem_bus.mem_wdata, 32'd7);
      chk("sw_addr", mem_bus.mem_addr, 32'h200);
      chk("sw_size", 32'(mem_bus.mem_size), 32'd2);
      mem_bus.mem_done = 1'b1;
      tick();
      mem_bus.mem_done = 1'b0;
      chk("sw_done_req", 32'(mem_bus.mem_req), 32'd0);
      chk("sw_no_load_res", 32'(res_load_valid), 32'd0);

      // fill to 15 from a clean ring, then drain across the wrap
      rst = 1'b0; tick(); rst = 1'b1; tick();
      for (int i = 0; i < 15; i++) begin
         issue(OP_LW, 4'(i), 32'h0, 32'(i * 4), {1'b1, 4'd9}, 32'd0, 5'd0);
         if (i == 13) chk("full_at_14", 32'(full), 32'd0);
      end
      chk("full_at_15", 32'(full), 32'd1);
      chk("fill_no_req", 32'(mem_bus.mem_req), 32'd0);
      cdb_valid = 1'b1; cdb_robid = 4'd9; cdb_value = 32'h1000;
      tick();
      cdb_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         wait_req("drain_req");
         chk("drain_addr", mem_bus.mem_addr, (k == 15) ? 32'h2000 : 32'h1000 + 32'(k * 4));
         mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 32'(k);
         if (k == 0) begin
            iss_valid = 1'b1; iss_op = OP_LW; iss_robid = 4'd15; iss_imm = 32'd0;
            iss_v1 = 32'h2000; iss_q1 = 5'd0; iss_q2 = 5'd0;
         end
         tick();
         mem_bus.mem_done = 1'b0; iss_valid = 1'b0;
         chk("drain_rvalid", 32'(res_load_valid), 32'd1);
         chk("drain_robid", 32'(res_robid), 32'(k));
         if (k == 0) chk("pop_issue_full", 32'(full), 32'd1);
         if (k == 1) chk("drain_14_full", 32'(full), 32'd0);
      end
      do_load("wrap", OP_LW, 4'd7, 32'h40, 32'h0, 32'h55, 32'h55, 2'd2);

      // flush while a committed store is in flight
      issue(OP_SW, 4'd1, 32'h80, 32'h0, 5'd0, 32'hAA, 5'd0);
      issue(OP_LW, 4'd10, 32'h0, 32'h0, {1'b1, 4'd12}, 32'd0, 5'd0);
      issue(OP_LW, 4'd11, 32'h0, 32'h4, {1'b1, 4'd12}, 32'd0, 5'd0);
      issue(OP_LW, 4'd12, 32'h0, 32'h8, {1'b1, 4'd12}, 32'd0, 5'd0);
      commit_store_valid = 1'b1; commit_store_robid = 4'd1;
      tick();
      commit_store_valid = 1'b0;
      chk("fst_req", 32'(mem_bus.mem_req), 32'd1);
      chk("fst_wdata", mem_bus.mem_wdata, 32'hAA);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fst_req_kept", 32'(mem_bus.mem_req), 32'd1);
      chk("fst_we_kept", 32'(mem_bus.mem_we), 32'd1);
      mem_bus.mem_done = 1'b1;
      tick();
      mem_bus.mem_done = 1'b0;
      chk("fst_done", 32'(mem_bus.mem_req), 32'd0);
      cdb_valid = 1'b1; cdb_robid = 4'd12; cdb_value = 32'h500;
      tick();
      cdb_valid = 1'b0;
      tick(); tick(); tick();
      chk("fst_empty", 32'(mem_bus.mem_req), 32'd0);
      do_load("fst_after", OP_LW, 4'd2, 32'h600, 32'h0, 32'h77, 32'h77, 2'd2);

      // flush while a load is in flight, late completion ignored
      issue(OP_LW, 4'd4, 32'h700, 32'h0, 5'd0, 32'd0, 5'd0);
      wait_req("fld_req");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fld_req_drop", 32'(mem_bus.mem_req), 32'd0);
      chk("fld_no_res", 32'(res_load_valid), 32'd0);
      mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 32'h99;
      tick();
      mem_bus.mem_done = 1'b0;
      chk("fld_late_done", 32'(res_load_valid), 32'd0);
      tick();
      chk("fld_late_done2", 32'(res_load_valid), 32'd0);
      chk("fld_idle", 32'(mem_bus.mem_req), 32'd0);

      // rdy low holds, then asynchronous reset mid-load
      issue(OP_LW, 4'd6, 32'h800, 32'h10, 5'd0, 32'd0, 5'd0);
      wait_req("rl_req");
      chk("rl_addr", mem_bus.mem_addr, 32'h810);
      rdy = 1'b0; mem_bus.mem_done = 1'b1;
      tick();
      mem_bus.mem_done = 1'b0;
      chk("rdy_hold_req", 32'(mem_bus.mem_req), 32'd1);
      chk("rdy_hold_nores", 32'(res_load_valid), 32'd0);
      rdy = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_req", 32'(mem_bus.mem_req), 32'd0);
      chk("arst_addr", mem_bus.mem_addr, 32'd0);
      chk("arst_size", 32'(mem_bus.mem_size), 32'd0);
      chk("arst_value", res_value, 32'd0);
      chk("arst_robid", 32'(res_robid), 32'd0);
      chk("arst_full", 32'(full), 32'd0);
      tick();
      rst = 1'b1;
      tick(); tick(); tick();
      chk("arst_empty", 32'(mem_bus.mem_req), 32'd0);
      do_load("arst_after", OP_LW, 4'd9, 32'h900, 32'h0, 32'hABC, 32'hABC, 2'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
